// File: rtl/inc_dec_sequencer.sv
// Round-robin sharing of one external 8-bit incrementer/decrementer; 16-bit ops run low byte then high byte.
// Optional INC_SEQ_EARLY_EXIT_EN: a 16-bit op with no carry out of the low byte skips the HIGH pass.
module inc_dec_sequencer #(
    parameter int NUM_REQ = 3
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset_n,
    input  logic [NUM_REQ-1:0]     i_Req,
    input  logic [16*NUM_REQ-1:0]  i_Operand,
    input  logic [NUM_REQ-1:0]     i_Wide,
    input  logic [NUM_REQ-1:0]     i_Decrement,
    input  logic [3:0]             i_F,
    output logic [7:0]             o_Inc_A,
    output logic [3:0]             o_Inc_F,
    output logic                   o_Inc_Decrement,
    input  logic [7:0]             i_Inc_A,
    input  logic [3:0]             i_Inc_F,
    output logic                   o_Busy,
    output logic [NUM_REQ-1:0]     o_Ack,
    output logic [15:0]            o_Result,
    output logic [3:0]             o_F,
    output logic                   o_F_Write
);

    // state  | meaning
    // S_IDLE | waiting for a request; arbitration and operand capture
    // S_LOW  | incrementer works on operand low byte
    // S_HIGH | incrementer works on operand high byte (16-bit ops)
    // S_DONE | one-cycle ack with result and flags
    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr_q, grant_q, grant, grant_inc;
    logic             found;
    int               idx;
    logic [15:0]      op_sel, op_q;
    logic             wide_sel, dec_sel, wide_q, dec_q;
    logic [3:0]       f_q, flags_q;
    logic [7:0]       res_lo_q, res_hi_q;
    logic             carry_q, carry_now;

    // First requester at or above the pointer, wrapping at NUM_REQ.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && i_Req[IDX_W'(idx)]) begin
                found = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        op_sel   = '0;
        wide_sel = 1'b0;
        dec_sel  = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant == IDX_W'(r)) begin
                op_sel   = i_Operand[16*r +: 16];
                wide_sel = i_Wide[r];
                dec_sel  = i_Decrement[r];
            end
        end
    end

    assign grant_inc = (grant == IDX_W'(NUM_REQ-1)) ? '0 : grant + IDX_W'(1);
    assign carry_now = dec_q ? (op_q[7:0] == 8'h00) : (i_Inc_A == 8'h00);

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        o_Inc_A         = '0;
        o_Inc_F         = '0;
        o_Inc_Decrement = 1'b0;
        o_Busy          = (state != S_IDLE);
        o_Ack           = '0;
        o_Result        = '0;
        o_F             = '0;
        o_F_Write       = 1'b0;
        case (state)
            S_IDLE: if (found) state_nxt = S_LOW;
            S_LOW: begin
                o_Inc_A         = op_q[7:0];
                o_Inc_F         = f_q;
                o_Inc_Decrement = dec_q;
`ifdef INC_SEQ_EARLY_EXIT_EN
                state_nxt       = (wide_q && carry_now) ? S_HIGH : S_DONE;
`else
                state_nxt       = wide_q ? S_HIGH : S_DONE;
`endif
            end
            S_HIGH: begin
                o_Inc_A         = op_q[15:8];
                o_Inc_F         = f_q;
                o_Inc_Decrement = dec_q;
                state_nxt       = S_DONE;
            end
            S_DONE: begin
                o_Ack     = NUM_REQ'(1) << grant_q;
                o_Result  = wide_q ? {res_hi_q, res_lo_q} : {8'h00, res_lo_q};
                // 16-bit INC/DEC leaves the flags as they were at grant
                o_F       = wide_q ? f_q : flags_q;
                o_F_Write = !wide_q;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            ptr_q    <= '0;
            grant_q  <= '0;
            op_q     <= '0;
            wide_q   <= 1'b0;
            dec_q    <= 1'b0;
            f_q      <= '0;
            flags_q  <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (found) begin
                    grant_q <= grant;
                    ptr_q   <= grant_inc;
                    op_q    <= op_sel;
                    wide_q  <= wide_sel;
                    dec_q   <= dec_sel;
                    f_q     <= i_F;
                end
                S_LOW: begin
                    res_lo_q <= i_Inc_A;
                    flags_q  <= i_Inc_F;
                    carry_q  <= carry_now;
                    res_hi_q <= op_q[15:8];
                end
                S_HIGH: if (carry_q) res_hi_q <= i_Inc_A;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inc_dec_sequencer.sv
// Bench for inc_dec_sequencer: directed vector table, hand-written corner sequences and
// randomized round-robin traffic against an arithmetic reference model.
module tb_inc_dec_sequencer;
    localparam int N = 3;

`ifdef INC_SEQ_EARLY_EXIT_EN
    localparam int LAT_NC = 2;
`else
    localparam int LAT_NC = 3;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req = '0, wide = '0, dec = '0;
    logic [16*N-1:0]   operand = '0;
    logic [3:0]        f_in = '0;
    logic [7:0]        inc_a_o, inc_a_i;
    logic [3:0]        inc_f_o, inc_f_i;
    logic              inc_dec;
    logic              busy;
    logic [N-1:0]      ack;
    logic [15:0]       result;
    logic [3:0]        f_out;
    logic              fw;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    inc_dec_sequencer #(.NUM_REQ(N)) dut (
        .i_Clk(clk), .i_Reset_n(rst_n), .i_Req(req), .i_Operand(operand),
        .i_Wide(wide), .i_Decrement(dec), .i_F(f_in),
        .o_Inc_A(inc_a_o), .o_Inc_F(inc_f_o), .o_Inc_Decrement(inc_dec),
        .i_Inc_A(inc_a_i), .i_Inc_F(inc_f_i),
        .o_Busy(busy), .o_Ack(ack), .o_Result(result), .o_F(f_out), .o_F_Write(fw)
    );

    // Flags of an 8-bit INC/DEC {Z,N,H,C}; carry flag is untouched.
    function automatic logic [3:0] inc_flags(input logic [7:0] a, input logic d, input logic [3:0] f);
        logic [7:0] r;
        r = d ? a - 8'd1 : a + 8'd1;
        return {r == 8'h00, d, d ? (a[3:0] == 4'h0) : (a[3:0] == 4'hF), f[0]};
    endfunction

    // External incrementer
    assign inc_a_i = inc_dec ? inc_a_o - 8'd1 : inc_a_o + 8'd1;
    assign inc_f_i = inc_flags(inc_a_o, inc_dec, inc_f_o);

    function automatic logic [15:0] model_result(input logic w, input logic d, input logic [15:0] op);
        logic [7:0] lo;
        if (w) return d ? op - 16'd1 : op + 16'd1;
        lo = d ? op[7:0] - 8'd1 : op[7:0] + 8'd1;
        return {8'h00, lo};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        tick();
    endtask

    typedef struct {
        int          idx;
        logic        w;
        logic        d;
        logic [15:0] op;
        logic [3:0]  f;
        logic [15:0] res;
        logic [3:0]  fo;
        logic        fw;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    // Single requester op; inputs are scrambled right after grant to prove capture.
    task automatic run_op(input string tag, input int idx, input logic w, input logic d,
                          input logic [15:0] op, input logic [3:0] f, input logic [15:0] eres,
                          input logic [3:0] ef, input logic efw, input int elat);
        int   lat;
        logic got;
        req = '0;
        req[idx] = 1'b1;
        wide[idx] = w;
        dec[idx] = d;
        operand[16*idx +: 16] = op;
        f_in = f;
        tick();
        chk({tag, "_busy"}, busy, 1'b1);
        operand[16*idx +: 16] = ~op;
        wide[idx] = ~w;
        dec[idx] = ~d;
        f_in = ~f;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 8) begin
            if (ack != '0) got = 1'b1;
            else begin
                tick();
                lat++;
            end
        end
        chk({tag, "_ack_seen"}, got, 1'b1);
        if (got) begin
            chk({tag, "_ack"}, ack, 1 << idx);
            chk({tag, "_res"}, result, eres);
            chk({tag, "_f"}, f_out, ef);
            chk({tag, "_fw"}, fw, efw);
            chk({tag, "_lat"}, lat, elat);
        end
        req = '0;
        tick();
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    // Wait for the next ack, bounded; returns 0 on timeout.
    task automatic wait_ack(output logic got);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack == '0 && n < 8);
        got = (ack != '0);
    endtask

    initial begin
        logic        got, seen;
        int          ptr, g;
        logic [N-1:0] pending;
        logic [15:0] op_a [N];
        logic        w_a [N], d_a [N];
        logic [3:0]  f_at_grant;
        int          order [4];

        vecs[0] = '{0, 1'b0, 1'b0, 16'h000F, 4'b0001, 16'h0010, 4'b0011, 1'b1, 2};
        vecs[1] = '{1, 1'b0, 1'b1, 16'h0001, 4'b0000, 16'h0000, 4'b1100, 1'b1, 2};
        vecs[2] = '{2, 1'b1, 1'b0, 16'h00FF, 4'b1010, 16'h0100, 4'b1010, 1'b0, 3};
        vecs[3] = '{0, 1'b1, 1'b1, 16'h0000, 4'b0110, 16'hFFFF, 4'b0110, 1'b0, 3};
        vecs[4] = '{1, 1'b1, 1'b0, 16'hFFFF, 4'b1001, 16'h0000, 4'b1001, 1'b0, 3};
        vecs[5] = '{2, 1'b0, 1'b0, 16'hABFF, 4'b0000, 16'h0000, 4'b1010, 1'b1, 2};
        vecs[6] = '{0, 1'b0, 1'b1, 16'h0010, 4'b0001, 16'h000F, 4'b0111, 1'b1, 2};
        vecs[7] = '{1, 1'b1, 1'b0, 16'h1234, 4'b0101, 16'h1235, 4'b0101, 1'b0, LAT_NC};
        vecs[8] = '{2, 1'b1, 1'b1, 16'h1200, 4'b1111, 16'h11FF, 4'b1111, 1'b0, 3};
        vecs[9] = '{0, 1'b1, 1'b1, 16'h1201, 4'b0000, 16'h1200, 4'b0000, 1'b0, LAT_NC};

        // Reset state
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, '0);
        chk("rst_result", result, 16'h0000);
        chk("rst_f", f_out, 4'h0);
        chk("rst_fw", fw, 1'b0);
        chk("rst_inc_a", inc_a_o, 8'h00);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].idx, vecs[i].w, vecs[i].d, vecs[i].op,
                   vecs[i].f, vecs[i].res, vecs[i].fo, vecs[i].fw, vecs[i].lat);

        // All three requesting and held: strict rotation 0,1,2,0
        do_reset();
        operand = {16'h0000, 16'h0100, 16'h0010};
        wide = 3'b010;
        dec = 3'b110;
        f_in = 4'b0000;
        req = 3'b111;
        order = '{0, 1, 2, 0};
        for (int i = 0; i < 4; i++) begin
            g = order[i];
            wait_ack(got);
            chk($sformatf("rr%0d_seen", i), got, 1'b1);
            if (got) begin
                chk($sformatf("rr%0d_ack", i), ack, 1 << g);
                chk($sformatf("rr%0d_res", i), result,
                    model_result(wide[g], dec[g], operand[16*g +: 16]));
            end
        end
        req = '0;
        tick();
        tick();

        // Reset in HIGH aborts without ack
        do_reset();
        req = 3'b001;
        wide = 3'b001;
        dec = 3'b000;
        operand[15:0] = 16'h00FF;
        tick();
        tick();
        chk("abort_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_ack", ack, '0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack != '0 || busy) seen = 1'b1;
        end
        chk("abort_no_ack", seen, 1'b0);
        run_op("post_abort", 1, 1'b1, 1'b0, 16'h1234, 4'b0011, 16'h1235, 4'b0011, 1'b0, LAT_NC);

        // Randomized traffic vs round-robin model
        do_reset();
        ptr = 0;
        for (int b = 0; b < 20; b++) begin
            pending = N'($urandom_range(1, (1 << N) - 1));
            for (int r = 0; r < N; r++) begin
                op_a[r] = 16'($urandom());
                w_a[r] = 1'($urandom());
                d_a[r] = 1'($urandom());
                operand[16*r +: 16] = op_a[r];
                wide[r] = w_a[r];
                dec[r] = d_a[r];
            end
            f_in = 4'($urandom());
            req = pending;
            while (pending != '0) begin
                f_at_grant = f_in;
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && pending[(ptr + k) % N]) g = (ptr + k) % N;
                wait_ack(got);
                chk($sformatf("rnd%0d_seen", b), got, 1'b1);
                if (!got) begin
                    pending = '0;
                    req = '0;
                    do_reset();
                    ptr = 0;
                end else begin
                    chk($sformatf("rnd%0d_ack", b), ack, 1 << g);
                    chk($sformatf("rnd%0d_res", b), result, model_result(w_a[g], d_a[g], op_a[g]));
                    chk($sformatf("rnd%0d_f", b), f_out,
                        w_a[g] ? f_at_grant : inc_flags(op_a[g][7:0], d_a[g], f_at_grant));
                    chk($sformatf("rnd%0d_fw", b), fw, !w_a[g]);
                    ptr = (g + 1) % N;
                    pending[g] = 1'b0;
                    req = pending;
                    op_a[g] = 16'($urandom());
                    operand[16*g +: 16] = op_a[g];
                    f_in = 4'($urandom());
                end
            end
        end
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end
endmodule
